// File: rtl/mem_bus_responder.sv
// Word-addressed SRAM responder for the memory manager's read/write bus.
// Handles one request at a time with a fixed latency and returns a one-cycle response.
module mem_bus_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2    // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_in,
  input  logic [31:0] data_in,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] data_out,
  output logic        bus_full,
  output logic        data_valid,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          counter;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic                op_read_q;
  logic [31:0]         mem [2**ADDR_W];

  logic                addr_err;
  logic [ADDR_W-1:0]   idx;
  logic                commit;

  assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
  assign idx       = addr_q[ADDR_W+1:2];
  assign commit    = (state == BUSY) && (counter == 4'd0);
  assign dbg_state = state;

  // Handshake: memRead/memWrite are levels sampled only in IDLE; bus_full is high
  // from acceptance through the response cycle, and data_valid strobes for exactly
  // one cycle with err qualifying it. Requests seen while bus_full is high are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      counter    <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      op_read_q  <= 1'b0;
      data_out   <= 32'h0;
      bus_full   <= 1'b0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memRead || memWrite) begin
            addr_q    <= address_in;
            wdata_q   <= data_in;
            op_read_q <= memRead;
            counter   <= 4'(LATENCY - 1);
            bus_full  <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (counter == 4'd0) begin
            state      <= RESP;
            data_valid <= 1'b1;
            err        <= addr_err;
            if (addr_err) data_out <= 32'h0;
            else if (op_read_q) data_out <= mem[idx];
          end else begin
            counter <= counter - 4'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          bus_full   <= 1'b0;
          data_valid <= 1'b0;
          err        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Contents survive reset; an aborted request never reaches commit because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (commit && !op_read_q && !addr_err) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboarded bench for mem_bus_responder: directed scenarios plus random requests
// checked against a word-array reference model.
module tb_mem_bus_responder;

  localparam int LAT = 2;
  localparam int AW  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address_in = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [31:0] data_out;
  logic        bus_full;
  logic        data_valid;
  logic        err;
  logic [1:0]  dbg_state;

  mem_bus_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .address_in(address_in), .data_in(data_in),
    .memRead(memRead), .memWrite(memWrite), .data_out(data_out),
    .bus_full(bus_full), .data_valid(data_valid), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  // expected response: {response cycle stamp[15:0], err, data_out[31:0]}
  logic [48:0] exp_q[$];

  // reference model
  logic [31:0] mdl_mem [2**AW];
  logic [31:0] mdl_last = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic rd, input logic wr,
                                        input logic [31:0] addr, input logic [31:0] data);
    logic bad;
    int   w;
    bad = (addr % 4 != 0) || (addr >= 32'(4 * (2**AW)));
    w   = int'(addr / 4) % (2**AW);
    if (bad) begin
      mdl_last = 32'h0;
      return {1'b1, 32'h0};
    end
    if (rd) begin
      mdl_last = mdl_mem[w];
      return {1'b0, mdl_last};
    end
    if (wr) mdl_mem[w] = data;
    return {1'b0, mdl_last};
  endfunction

  // Present a request at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input bit expect_resp);
    logic [32:0] r;
    @(negedge clk);
    memRead = rd; memWrite = wr; address_in = addr; data_in = data;
    @(posedge clk);
    #1;
    if (expect_resp) begin
      r = model(rd, wr, addr, data);
      exp_q.push_back({16'(cyc + LAT), r});
    end
    memRead = 1'b0; memWrite = 1'b0;
    chk("bus_full_after_accept", 64'(bus_full), 64'd1);
  endtask

  task automatic finish_resp();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!data_valid && k < 40);
    if (!data_valid) chk("resp_timeout", 64'(data_valid), 64'd1);
    else chk("bus_full_in_resp", 64'(bus_full), 64'd1);
    @(posedge clk);
    #1;
    chk("idle_after_resp", {62'h0, bus_full, data_valid}, 64'd0);
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    issue(rd, wr, addr, data, 1'b1);
    finish_resp();
  endtask

  // Monitor: every response is popped and compared, including its arrival cycle.
  always @(negedge clk) begin
    if (rst && data_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", {31'h0, err, data_out}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("response", 64'({16'(cyc), err, data_out}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int op, kind;
    // reset held 3 cycles, then 5 idle cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {data_out, 29'h0, bus_full, data_valid, err}, 64'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", {data_out, 29'h0, bus_full, data_valid, err}, 64'd0);
    end

    // known contents for the low 64 words
    for (int i = 0; i < 64; i++) req(1'b0, 1'b1, 32'(i * 4), $urandom);
    req(1'b0, 1'b1, 32'hC, 32'h0);
    req(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5);

    // write then read back
    req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    req(1'b1, 1'b0, 32'h40, 32'h0);

    // write pulse while busy must be dropped
    issue(1'b0, 1'b1, 32'h8, 32'h1, 1'b1);
    @(negedge clk);
    memWrite = 1'b1; address_in = 32'hC; data_in = 32'h2;
    @(negedge clk);
    memWrite = 1'b0;
    finish_resp();
    req(1'b1, 1'b0, 32'hC, 32'h0);

    // errors: misaligned read, out-of-range write, word 0 untouched
    req(1'b1, 1'b0, 32'h41, 32'h0);
    req(1'b0, 1'b1, 32'h1000, 32'h5);
    req(1'b1, 1'b0, 32'h0, 32'h0);

    // read wins over write
    req(1'b1, 1'b1, 32'h10, 32'h0);
    req(1'b1, 1'b0, 32'h10, 32'h0);

    // reset during BUSY aborts the write
    issue(1'b0, 1'b1, 32'h20, 32'h77, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mdl_last = 32'h0;
    #1;
    chk("abort_outputs", {data_out, 29'h0, bus_full, data_valid, err}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req(1'b1, 1'b0, 32'h20, 32'h0);

    // random traffic
    for (int n = 0; n < 120; n++) begin
      op   = $urandom_range(0, 8);
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 63) * 4);
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = a | {12'($urandom_range(1, 4095)), 20'h0};
      d = $urandom;
      if (op < 4) req(1'b1, 1'b0, a, d);
      else if (op < 8) req(1'b0, 1'b1, a, d);
      else req(1'b1, 1'b1, a, d);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
